// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// Handles stall, branch redirect with wrong-path squash, and counts valid fetches.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   output logic [31:0] readAddress,
   output logic [31:0] ifidInstr,
   output logic [31:0] ifidPc,
   output logic [31:0] ifidPcPlus4,
   output logic        ifidValid,
   output logic        alignFault,
   output logic [31:0] fetchCount
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic        valid_q, valid_d;
   logic        align_q, align_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pc_next;

   assign pc_next = pc_q + PC_STEP;

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      align_d = 1'b0;
      // A redirect squashes the word fetched this cycle, even if stalled.
      if (branchTaken) begin
         pc_d    = {branchTarget[31:2], 2'b00};
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         align_d = |branchTarget[1:0];
      end else if (!stall) begin
         pc_d    = pc_next;
         instr_d = instruction;
         ipc_d   = pc_q;
         ipc4_d  = pc_next;
         valid_d = 1'b1;
         cnt_d   = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         ipc_q   <= 32'h0;
         ipc4_q  <= 32'h0;
         valid_q <= 1'b0;
         align_q <= 1'b0;
         cnt_q   <= 32'h0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         ipc4_q  <= ipc4_d;
         valid_q <= valid_d;
         align_q <= align_d;
         cnt_q   <= cnt_d;
      end
   end

   assign readAddress = pc_q;
   assign ifidInstr   = instr_q;
   assign ifidPc      = ipc_q;
   assign ifidPcPlus4 = ipc4_q;
   assign ifidValid   = valid_q;
   assign alignFault  = align_q;
   assign fetchCount  = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table plus an async-reset sequence.
module tb_instruction_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic        stall;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic [31:0] readAddress;
   logic [31:0] ifidInstr;
   logic [31:0] ifidPc;
   logic [31:0] ifidPcPlus4;
   logic        ifidValid;
   logic        alignFault;
   logic [31:0] fetchCount;

   int n_pass;
   int n_total;

   instruction_fetch dut (
      .clk(clk),
      .reset(reset),
      .instruction(instruction),
      .stall(stall),
      .branchTaken(branchTaken),
      .branchTarget(branchTarget),
      .readAddress(readAddress),
      .ifidInstr(ifidInstr),
      .ifidPc(ifidPc),
      .ifidPcPlus4(ifidPcPlus4),
      .ifidValid(ifidValid),
      .alignFault(alignFault),
      .fetchCount(fetchCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: each word encodes its own address.
   function automatic logic [31:0] word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign instruction = word(readAddress);

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct {
      logic        st;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] ra;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        v;
      logic        af;
      logic [31:0] cnt;
   } vec_t;

   vec_t vt[17];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk_all(input string tag, input vec_t e);
      chk({tag, " readAddress"}, readAddress, e.ra);
      chk({tag, " ifidInstr"}, ifidInstr, e.ins);
      chk({tag, " ifidPc"}, ifidPc, e.pc);
      chk({tag, " ifidPcPlus4"}, ifidPcPlus4, e.pc4);
      chk({tag, " ifidValid"}, {31'd0, ifidValid}, {31'd0, e.v});
      chk({tag, " alignFault"}, {31'd0, alignFault}, {31'd0, e.af});
      chk({tag, " fetchCount"}, fetchCount, e.cnt);
   endtask

   initial begin
      vec_t rv;
      n_pass = 0;
      n_total = 0;
      // st br  tgt  | ra  ins  pc  pc4  v af cnt
      vt[0]  = '{0,0,32'h0,32'h4,word(32'h0),32'h0,32'h4,1,0,32'd1};
      vt[1]  = '{0,0,32'h0,32'h8,word(32'h4),32'h4,32'h8,1,0,32'd2};
      vt[2]  = '{1,0,32'h0,32'h8,word(32'h4),32'h4,32'h8,1,0,32'd2};
      vt[3]  = '{1,0,32'h0,32'h8,word(32'h4),32'h4,32'h8,1,0,32'd2};
      vt[4]  = '{1,0,32'h0,32'h8,word(32'h4),32'h4,32'h8,1,0,32'd2};
      vt[5]  = '{0,0,32'h0,32'hC,word(32'h8),32'h8,32'hC,1,0,32'd3};
      vt[6]  = '{0,0,32'h0,32'h10,word(32'hC),32'hC,32'h10,1,0,32'd4};
      vt[7]  = '{1,1,32'h40,32'h40,NOP,32'hC,32'h10,0,0,32'd4};
      vt[8]  = '{0,0,32'h0,32'h44,word(32'h40),32'h40,32'h44,1,0,32'd5};
      vt[9]  = '{0,1,32'h42,32'h40,NOP,32'h40,32'h44,0,1,32'd5};
      vt[10] = '{0,0,32'h0,32'h44,word(32'h40),32'h40,32'h44,1,0,32'd6};
      vt[11] = '{0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,NOP,32'h40,32'h44,0,0,32'd6};
      vt[12] = '{0,0,32'h0,32'h0,word(32'hFFFF_FFFC),32'hFFFF_FFFC,32'h0,1,0,32'd7};
      vt[13] = '{0,1,32'h8,32'h8,NOP,32'hFFFF_FFFC,32'h0,0,0,32'd7};
      vt[14] = '{1,1,32'h23,32'h20,NOP,32'hFFFF_FFFC,32'h0,0,1,32'd7};
      vt[15] = '{0,0,32'h0,32'h24,word(32'h20),32'h20,32'h24,1,0,32'd8};
      vt[16] = '{0,0,32'h0,32'h28,word(32'h24),32'h24,32'h28,1,0,32'd9};

      reset = 1'b1;
      stall = 1'b0;
      branchTaken = 1'b0;
      branchTarget = 32'h0;
      #12;
      rv = '{0,0,32'h0,32'h0,NOP,32'h0,32'h0,0,0,32'd0};
      chk_all("reset", rv);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         stall = vt[i].st;
         branchTaken = vt[i].br;
         branchTarget = vt[i].tgt;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vt[i]);
      end

      // Async reset between edges while running at pc=0x28.
      stall = 1'b0;
      branchTaken = 1'b0;
      branchTarget = 32'h0;
      #2;
      reset = 1'b1;
      #1;
      chk_all("async_rst", rv);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      rv = '{0,0,32'h0,32'h4,word(32'h0),32'h0,32'h4,1,0,32'd1};
      chk_all("post_rst", rv);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
